// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [2:0]       mode0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             c0,
  input  logic             req1,
  input  logic [2:0]       mode1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             c1,
  output logic             done0,
  output logic [WIDTH-1:0] result0,
  output logic             cout0,
  output logic             done1,
  output logic [WIDTH-1:0] result1,
  output logic             cout1,
  output logic [2:0]       alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1,
`endif
  output logic             busy
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [2:0] ZERO_MODE = 3'b110;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic gnt, last_grant, elig0, elig1, pick1, grant_any;
  always_comb begin
    elig0     = req0 & ~done0;
    elig1     = req1 & ~done1;
    pick1     = elig1 & (~elig0 | ~last_grant);
    grant_any = elig0 | elig1;
    state_nx  = state;
    state_nx  = (state == IDLE) ? (grant_any ? WAIT : IDLE) :
                (state == WAIT) ? ((cnt == '0) ? CAPTURE : WAIT) : IDLE;
  end
  assign busy = (state != IDLE);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      alu_mode   <= ZERO_MODE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result0    <= '0;
      result1    <= '0;
      cout0      <= 1'b0;
      cout1      <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      gnt_cnt0   <= '0;
      gnt_cnt1   <= '0;
`endif
    end else begin
      state <= state_nx;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == IDLE && grant_any) begin
        gnt      <= pick1;
        alu_mode <= pick1 ? mode1 : mode0;
        alu_a    <= pick1 ? a1 : a0;
        alu_b    <= pick1 ? b1 : b0;
        alu_c    <= pick1 ? c1 : c0;
        cnt      <= CW'(SETTLE_CYCLES - 1);
`ifdef ALU_ARB_STATS_EN
        if (!pick1 && gnt_cnt0 != 8'hff) gnt_cnt0 <= gnt_cnt0 + 8'd1;
        if (pick1 && gnt_cnt1 != 8'hff) gnt_cnt1 <= gnt_cnt1 + 8'd1;
`endif
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (state == CAPTURE) begin
        if (gnt) begin
          result1 <= alu_result;
          cout1   <= alu_cout;
          done1   <= 1'b1;
        end else begin
          result0 <= alu_result;
          cout0   <= alu_cout;
          done0   <= 1'b1;
        end
        last_grant <= gnt;
        alu_mode   <= ZERO_MODE;
        alu_a      <= '0;
        alu_b      <= '0;
        alu_c      <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors and corner sequences for alu_arbiter with a bench-side ALU.
module tb_alu_arbiter;
  logic clock = 1'b0, reset = 1'b0;
  logic req0 = 0, req1 = 0, c0 = 0, c1 = 0;
  logic [2:0] mode0 = 0, mode1 = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic done0, done1, cout0, cout1, alu_c, alu_cout, busy;
  logic [3:0] result0, result1, alu_a, alu_b, alu_result;
  logic [2:0] alu_mode;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif
  int errors = 0, checks = 0;

  alu_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .mode0(mode0), .a0(a0), .b0(b0), .c0(c0),
    .req1(req1), .mode1(mode1), .a1(a1), .b1(b1), .c1(c1),
    .done0(done0), .result0(result0), .cout0(cout0),
    .done1(done1), .result1(result1), .cout1(cout1),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_result(alu_result), .alu_cout(alu_cout),
`ifdef ALU_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference ALU: 000 A, 001 add, 010 and, 011 or, 100 xor, 101 rotate-left through carry, 110 zero, 111 not A
  always_comb begin
    alu_result = 4'h0;
    alu_cout   = 1'b0;
    case (alu_mode)
      3'd0: alu_result = alu_a;
      3'd1: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_c};
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: {alu_cout, alu_result} = {alu_a, alu_c};
      3'd6: alu_result = 4'h0;
      default: alu_result = ~alu_a;
    endcase
  end

  typedef struct {
    bit id; logic [2:0] mode; logic [3:0] a, b; logic c; logic [3:0] r; logic co;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit id, input logic [2:0] m, input logic [3:0] a, input logic [3:0] b, input logic c);
    if (id) begin req1 = 1; mode1 = m; a1 = a; b1 = b; c1 = c; end
    else begin req0 = 1; mode0 = m; a0 = a; b0 = b; c0 = c; end
  endtask

  task automatic wait_done(input bit id, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(id ? done1 : done0) && n < 20);
  endtask

  task automatic finish_op(input bit id, input logic [3:0] er, input logic ec);
    int n;
    wait_done(id, n);
    chk("latency", n, 4);
    chk("result", id ? result1 : result0, er);
    chk("cout", id ? cout1 : cout0, ec);
    if (id) req1 = 0; else req0 = 0;
    @(negedge clock);
    chk("done_pulse", id ? done1 : done0, 0);
    chk("result_hold", id ? result1 : result0, er);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    v[0] = '{0, 3'b001, 4'h9, 4'h8, 1'b1, 4'h2, 1'b1};
    v[1] = '{0, 3'b010, 4'hC, 4'hA, 1'b0, 4'h8, 1'b0};
    v[2] = '{1, 3'b011, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
    v[3] = '{1, 3'b101, 4'hA, 4'h0, 1'b1, 4'h5, 1'b1};
    v[4] = '{0, 3'b000, 4'h5, 4'h3, 1'b0, 4'h5, 1'b0};
    v[5] = '{1, 3'b100, 4'hF, 4'h5, 1'b0, 4'hA, 1'b0};
    v[6] = '{0, 3'b001, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    v[7] = '{1, 3'b111, 4'h3, 4'h0, 1'b0, 4'hC, 1'b0};
    v[8] = '{0, 3'b110, 4'h7, 4'h7, 1'b1, 4'h0, 1'b0};
    v[9] = '{1, 3'b001, 4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
    drive(0, 3'b001, 4'h9, 4'h8, 1'b1);
    repeat (2) @(negedge clock);
    chk("rst_alu_mode", alu_mode, 3'b110);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_c", alu_c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_result", {result0, result1, cout0, cout1}, 0);
    reset = 1;
    @(negedge clock);
    chk("grant_busy", busy, 1);
    chk("grant_alu_a", alu_a, 4'h9);
    chk("grant_alu_mode", alu_mode, 3'b001);
    wait_done(0, n);
    chk("add_latency", n, 3);
    chk("add_result", result0, 4'h2);
    chk("add_cout", cout0, 1);
    req0 = 0;
    @(negedge clock);
    chk("add_done_low", done0, 0);
    chk("add_hold", result0, 4'h2);
    chk("idle_alu_mode", alu_mode, 3'b110);
    for (int i = 0; i < 10; i++) begin
      drive(v[i].id, v[i].mode, v[i].a, v[i].b, v[i].c);
      finish_op(v[i].id, v[i].r, v[i].co);
    end
    reset = 0;
    @(negedge clock);
    reset = 1;
    drive(0, 3'b010, 4'hC, 4'hA, 1'b0);
    drive(1, 3'b011, 4'h3, 4'h4, 1'b0);
    wait_done(0, n);
    chk("cont_lat0", n, 4);
    chk("cont_result0", result0, 4'h8);
    chk("cont_done1_low", done1, 0);
    req0 = 0;
    wait_done(1, n);
    chk("cont_lat1", n, 4);
    chk("cont_result1", result1, 4'h7);
    req1 = 0;
    @(negedge clock);
    drive(0, 3'b000, 4'h6, 4'h0, 1'b0);
    drive(1, 3'b000, 4'h9, 4'h0, 1'b0);
    wait_done(0, n);
    chk("rr_lat0", n, 4);
    chk("rr_result0", result0, 4'h6);
    chk("rr_done1_low", done1, 0);
    wait_done(1, n);
    chk("rr_lat1", n, 4);
    chk("rr_result1", result1, 4'h9);
    chk("rr_no_reserve0", done0, 0);
    req1 = 0;
    wait_done(0, n);
    chk("held_req_reserved", n, 4);
    req0 = 0;
    @(negedge clock);
    drive(0, 3'b001, 4'h3, 4'h4, 1'b0);
    repeat (2) @(negedge clock);
    chk("abort_busy_before", busy, 1);
    reset = 0;
    #1;
    chk("abort_alu_mode", alu_mode, 3'b110);
    chk("abort_busy", busy, 0);
    chk("abort_alu_a", alu_a, 0);
    @(negedge clock);
    chk("abort_no_done", done0, 0);
    reset = 1;
    finish_op(0, 4'h7, 1'b0);
    drive(1, 3'b001, 4'h1, 4'h1, 1'b0);
    repeat (2) @(negedge clock);
    mode1 = 3'b110; a1 = 4'h0; req1 = 0;
    wait_done(1, n);
    chk("late_change_lat", n, 2);
    chk("late_change_result", result1, 4'h2);
`ifdef ALU_ARB_STATS_EN
    reset = 0;
    @(negedge clock);
    reset = 1;
    chk("stats_rst", {gnt_cnt0, gnt_cnt1}, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b000, 4'h1, 4'h0, 1'b0);
      finish_op(1, 4'h1, 1'b0);
    end
    chk("stats_cnt1", gnt_cnt1, 3);
    chk("stats_cnt0_zero", gnt_cnt0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(0, 3'b000, 4'h2, 4'h0, 1'b0);
      wait_done(0, n);
      req0 = 0;
      @(negedge clock);
    end
    chk("stats_sat0", gnt_cnt0, 255);
    chk("stats_cnt1_kept", gnt_cnt1, 3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit mode-selected ALU between two requesters (3-bit mode, A/B operands, carry-in, 4-bit result plus carry-out).
- Arbitrates requests round-robin and drives the ALU operand and mode inputs from registers.
- Waits a fixed settle time, because the ALU is gate-delay based with no internal register.
- Captures the result and carry and returns them to the winning requester with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand/result width
SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture; minimum 1, 0 is illegal

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req0  in  1  requester 0 request; level, held until done0
mode0  in  3  requester 0 ALU mode
a0  in  WIDTH  requester 0 operand A
b0  in  WIDTH  requester 0 operand B
c0  in  1  requester 0 carry-in
req1, mode1, a1, b1, c1  in  1/3/WIDTH/WIDTH/1  requester 1, same meaning
done0  out  1  one-cycle pulse: result0/cout0 valid
result0  out  WIDTH  last result for requester 0, held until next done0
cout0  out  1  last carry-out for requester 0, held until next done0
done1, result1, cout1  out  1/WIDTH/1  requester 1, same meaning
alu_mode  out  3  to ALU mode select
alu_a  out  WIDTH  to ALU operand A
alu_b  out  WIDTH  to ALU operand B
alu_c  out  1  to ALU carry-in
alu_result  in  WIDTH  from ALU result
alu_cout  in  1  from ALU carry-out
busy  out  1  high in WAIT and CAPTURE

Behaviour:
- Reset values (while reset=0, asynchronous):
  - State IDLE.
  - alu_mode=3'b110 (constant-zero mode); alu_a, alu_b, alu_c = 0.
  - done0/1=0, result0/1=0, cout0/1=0, busy=0.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - Eligible requester = reqN=1 and doneN=0; a requester still high in its own done cycle is not re-served.
  - No eligible requester: stay in IDLE; alu_mode=110, operands 0.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant edge: latch the winner's mode/a/b/c onto the alu_* registers, store grant id, load cnt=SETTLE_CYCLES-1, go to WAIT.
- WAIT:
  - alu_* held constant.
  - cnt==0 goes to CAPTURE; otherwise decrement cnt.
  - WAIT lasts exactly SETTLE_CYCLES cycles.
- CAPTURE (single cycle), on the edge leaving it:
  - resultN<=alu_result, coutN<=alu_cout, doneN<=1 for the granted requester.
  - last_grant<=granted id.
  - alu_mode<=110, operands<=0.
  - Go to IDLE.
- doneN is cleared on the following edge; exactly one cycle high.
- Latency: request sampled at edge E0, doneN high after edge E0+SETTLE_CYCLES+1 (default: 3 edges).
- Back-to-back: the other requester can be granted on the edge that clears the first done. Default throughput is one operation per 4 cycles.
- Requester inputs are sampled only at the grant edge. Changes or req deassertion during WAIT do not affect the operation; done still pulses.
- Reset mid-operation: immediate return to reset values; no done pulse for the aborted operation. A request still held after release is served from scratch.
- busy=1 exactly in WAIT and CAPTURE.
- Carry-out is captured for every mode. The value is whatever the ALU drives; nonzero only for the add and rotate modes.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 8 bits each.
  - Each increments at its requester's grant edge and saturates at 255.
  - Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 with req0=1 → all outputs at reset values, alu_mode=110, busy=0. Release → grant on the next edge.
- Add: req0, mode0=001, a0=4'h9, b0=4'h8, c0=1 → done0 after 3rd edge, result0=4'h2, cout0=1. result0 is held after done0 falls.
- Contention: req0 and req1 rise together after reset. Requester 0 has mode 010, A=4'hC, B=4'hA. Requester 1 has mode 011, A=4'h3, B=4'h4.
  → done0 first with result0=4'h8.
  → done1 four edges later with result1=4'h7.
  → next simultaneous pair grants requester 0 again, per the round-robin pointer.
- Rotate: req1, mode1=101, a1=4'b1010, c1=1 → result1=4'b0101, cout1=1.
- Abort: assert reset during WAIT → no done pulse, alu_mode=110. Release with req0 still high → result delivered 3 edges after the first post-release edge.
- Stats (ALU_ARB_STATS_EN): three grants to requester 1 → gnt_cnt1=3, gnt_cnt0=0. 300 grants to requester 0 → gnt_cnt0=255.
